// File: rtl/byte_word_assembler_pkg.sv
// Shared constants for the byte-to-word assembler.
//   DATA_WIDTH_DEF : default payload bits per input symbol
//   TAG_BIT        : index of the start-of-record tag in a default-width symbol
//   DROP_W/DROP_MAX: dropped-word counter width and its saturation value
//   lane_width()   : bits needed to hold a byte count 0..word_bytes
package byte_word_assembler_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned TAG_BIT        = DATA_WIDTH_DEF;
  localparam int unsigned DROP_W         = 16;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  function automatic int unsigned lane_width(input int unsigned word_bytes);
    return $clog2(word_bytes) + 1;
  endfunction

endpackage

// File: rtl/byte_word_assembler_fifo.sv
// word_fifo: synchronous FIFO, strict FIFO order.
//   push_i/wdata_i : write request (ignored when full unless popping this cycle)
//   pop_i          : read request (ignored when empty)
//   rdata_o        : head entry; holds the last popped entry while empty
//   full_o/empty_o : occupancy flags
module word_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, rd_q;
  logic [WIDTH-1:0] last_q;
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

  // A pop frees a slot in the same cycle, so push is accepted even when full.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign rdata_o = empty_o ? last_q : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      last_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) begin
        rd_q   <= rd_q + 1'b1;
        last_q <= mem_q[rd_q[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/byte_word_assembler.sv
// byte_word_assembler: packs a tagged byte stream into little-endian words.
//   in_data/in_valid   : symbol {tag, byte}; tag starts a new record
//   out_word/out_len   : FIFO head word (lane 0 in LSBs) and its byte count
//   out_valid/out_ready: valid/ready handshake on the FIFO head
//   overflow           : sticky, a word was dropped because the FIFO was full
//   drop_count         : saturating count of dropped words
module byte_word_assembler
  import byte_word_assembler_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned WORD_BYTES = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [DATA_WIDTH:0]                in_data,
  input  logic                               in_valid,
  output logic [WORD_BYTES*DATA_WIDTH-1:0]   out_word,
  output logic [lane_width(WORD_BYTES)-1:0]  out_len,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               overflow,
  output logic [DROP_W-1:0]                  drop_count
);

  localparam int unsigned LW     = lane_width(WORD_BYTES);
  localparam int unsigned WORD_W = WORD_BYTES * DATA_WIDTH;
  localparam logic [LW-1:0] LAST_LANE = LW'(WORD_BYTES - 1);

  logic [LW-1:0]         lane_q, lane_d;
  logic [WORD_W-1:0]     acc_q, acc_d, acc_fill;
  logic                  ovf_q, ovf_d;
  logic [DROP_W-1:0]     drop_q, drop_d;

  logic                  in_tag;
  logic [DATA_WIDTH-1:0] in_byte;
  logic                  emit, pop, drop;
  logic [WORD_W-1:0]     emit_word;
  logic [LW-1:0]         emit_len;
  logic                  fifo_full, fifo_empty;

  assign in_tag  = in_data[DATA_WIDTH];
  assign in_byte = in_data[DATA_WIDTH-1:0];

  always_comb begin
    emit      = 1'b0;
    emit_word = '0;
    emit_len  = '0;
    lane_d    = lane_q;
    acc_d     = acc_q;
    acc_fill  = acc_q;
    acc_fill[lane_q*DATA_WIDTH +: DATA_WIDTH] = in_byte;
    if (in_valid) begin
      if (in_tag && (lane_q != '0)) begin
        // Flush the partial word; the tagged byte opens a fresh accumulator.
        emit      = 1'b1;
        emit_word = acc_q;
        emit_len  = lane_q;
        acc_d     = '0;
        acc_d[DATA_WIDTH-1:0] = in_byte;
        lane_d    = LW'(1);
      end else if (lane_q == LAST_LANE) begin
        emit      = 1'b1;
        emit_word = acc_fill;
        emit_len  = LW'(WORD_BYTES);
        acc_d     = '0;
        lane_d    = '0;
      end else begin
        acc_d  = acc_fill;
        lane_d = lane_q + LW'(1);
      end
    end
  end

  assign pop  = out_valid && out_ready;
  assign drop = emit && fifo_full && !pop;

  always_comb begin
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != DROP_MAX) drop_d = drop_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q <= '0;
      acc_q  <= '0;
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      lane_q <= lane_d;
      acc_q  <= acc_d;
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
    end
  end

  word_fifo #(
    .WIDTH(WORD_W + LW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (emit),
    .wdata_i ({emit_word, emit_len}),
    .pop_i   (pop),
    .rdata_o ({out_word, out_len}),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign out_valid  = !fifo_empty;
  assign overflow   = ovf_q;
  assign drop_count = drop_q;

endmodule
